ram_arbiter: RTL

- Shares the single-port RAM between two requesters: port 0 = instruction fetch (FSM side), port 1 = data access (MOV/load/store execution).
- Sits between the FSM/datapath and the RAM instance.
- Owns all RAM enable/write/address/data strobes, so the RAM never sees two sources in one cycle.
- Provides a req/gnt/rvalid handshake per requester.

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_arb_pick.sv | 28 ++
 rtl/ram_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // One-hot request/grant vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        logic [1:0] oh;
        oh = 2'b00;
        if (port == PORT_DATA) oh[PORT_DATA]  = 1'b1;
        else                   oh[PORT_FETCH] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection for the RAM arbiter. Round-robin by default;
// RAM_ARB_FIXED_PRIO_EN selects fixed priority (data port always wins).
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       winner_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        winner_o = PORT_FETCH;
        if (req_i[PORT_DATA]) winner_o = PORT_DATA;
    end
`else
    // On a tie the port opposite the previous owner wins.
    always_comb begin
        winner_o = PORT_FETCH;
        if (req_i == 2'b11)        winner_o = ~last_owner_i;
        else if (req_i[PORT_DATA]) winner_o = PORT_DATA;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between fetch (port 0) and data (port 1) with req/gnt/rvalid.
// Arbitration mode set by RAM_ARB_FIXED_PRIO_EN inside ram_arb_pick (default round-robin).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              busy_q;

    logic              winner_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    ram_arb_pick u_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .winner_o     (winner_d)
    );

    assign we_d    = we[winner_d];
    assign addr_d  = (winner_d == PORT_DATA) ? addr1  : addr0;
    assign wdata_d = (winner_d == PORT_DATA) ? wdata1 : wdata0;

    // Access sequencer: IDLE arbitrates, ISSUE strobes the RAM, RESP captures read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= PORT_FETCH;
            last_owner_q <= PORT_DATA;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            rdata_q      <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        state_q     <= ISSUE;
                        owner_q     <= winner_d;
                        gnt_q       <= port_onehot(winner_d);
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= we_d;
                        ram_addr_q  <= addr_d;
                        ram_wdata_q <= wdata_d;
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    last_owner_q <= owner_q;
                    if (ram_we_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    rdata_q  <= ram_rdata;
                    rvalid_q <= port_onehot(owner_q);
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

endmodule
